// File: rtl/vegeta_output_pkg.sv
// vegeta_output_pkg: shared types and sizing for the VEGETA output streamer.
package vegeta_output_pkg;
   localparam int STREAM_ADDR_W = 16;
   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
   typedef struct packed {
      logic                     last;
      logic [STREAM_ADDR_W-1:0] addr;
      logic [31:0]              data;
   } stream_entry_t;
   function automatic int exp_words(input int m, input int n);
      return m * n;
   endfunction
endpackage

// File: rtl/vegeta_output_streamer_if.sv
// vegeta_output_streamer_if: valid/ready result stream with source address and job-end tag.
interface vegeta_output_streamer_if #(parameter int ADDR_W = 16);
   logic [31:0]       tdata;
   logic [ADDR_W-1:0] tuser;
   logic              tlast;
   logic              tvalid;
   logic              tready;
   modport master(output tdata, tuser, tlast, tvalid, input tready);
   modport slave(input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/vegeta_stream_fifo.sv
// vegeta_stream_fifo: registered sync FIFO of stream entries; a full FIFO accepts a push only alongside a pop.
module vegeta_stream_fifo
   import vegeta_output_pkg::*;
#(parameter int DEPTH = 16)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  stream_entry_t              din,
   output stream_entry_t              dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   stream_entry_t mem [DEPTH];
   logic [AW:0] wr, rd;
   logic do_push, do_pop;
   assign count = wr - rd;
   assign empty = wr == rd;
   assign full = count == (AW + 1)'(DEPTH);
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout = empty ? '0 : mem[rd[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr <= '0;
         rd <= '0;
      end else begin
         if (do_push) wr <= wr + 1'b1;
         if (do_pop) rd <= rd + 1'b1;
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/vegeta_output_streamer.sv
// vegeta_output_streamer: snoops the accelerator output-BRAM writes and replays each job as a tagged stream.
module vegeta_output_streamer
   import vegeta_output_pkg::*;
#(
   parameter int M      = 4,
   parameter int N      = 4,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = STREAM_ADDR_W
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_multiplication,
   input  logic                       compute_done,
   input  logic [31:0]                output_address,
   input  logic [31:0]                output_data,
   input  logic                       output_enable,
   input  logic [3:0]                 output_write,
   vegeta_output_streamer_if.master   m,
   output logic                       job_done,
   output logic                       busy,
   output logic                       err_overflow,
   output logic                       err_strobe,
   output logic                       err_length
);
   localparam int EXP = exp_words(M, N);
   localparam int CW = $clog2(EXP + 1);
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx, cnt_inc;
   logic seen, seen_nx, ovf_nx, stb_nx, len_nx;
   logic wr_full, wr_part, last, push, pop, full, empty;
   logic [$clog2(DEPTH):0] unused_count;
   logic unused_addr;
   stream_entry_t din, head;
   assign wr_full = output_enable && output_write == 4'hF;
   assign wr_part = output_enable && output_write != 4'h0 && output_write != 4'hF;
   assign last = cnt == CW'(EXP - 1);
   assign cnt_inc = cnt == CW'(EXP) ? cnt : cnt + 1'b1;
   assign din = '{last, output_address[STREAM_ADDR_W-1:0], output_data};
   assign unused_addr = ^output_address[31:STREAM_ADDR_W];
   assign pop = m.tvalid && m.tready;
   assign m.tvalid = !empty;
   assign m.tdata = head.data;
   assign m.tuser = ADDR_W'(head.addr);
   assign m.tlast = head.last;
   assign busy = state != IDLE;
   vegeta_stream_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din), .dout(head),
      .full(full), .empty(empty), .count(unused_count)
   );
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      seen_nx = seen;
      ovf_nx = err_overflow;
      stb_nx = err_strobe || (state != IDLE && wr_part);
      len_nx = err_length;
      push = 1'b0;
      job_done = 1'b0;
      case (state)
         IDLE: if (start_multiplication) begin
            state_nx = CAPTURE;
            cnt_nx = '0;
            seen_nx = 1'b0;
            ovf_nx = 1'b0;
            stb_nx = 1'b0;
            len_nx = 1'b0;
         end
         CAPTURE: begin
            push = wr_full;
            cnt_nx = wr_full ? cnt_inc : cnt;
            seen_nx = compute_done;
            len_nx = err_length || (compute_done && !(wr_full && last));
            state_nx = (compute_done || (wr_full && last)) ? DRAIN : CAPTURE;
         end
         default: begin
            len_nx = err_length || wr_full;
            job_done = empty && (compute_done || seen);
            state_nx = job_done ? IDLE : DRAIN;
         end
      endcase
      // A drop on a full FIFO still advanced the counter above, so tlast stays on word EXP-1.
      ovf_nx = ovf_nx || (push && full && !pop);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         seen <= 1'b0;
         err_overflow <= 1'b0;
         err_strobe <= 1'b0;
         err_length <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         seen <= seen_nx;
         err_overflow <= ovf_nx;
         err_strobe <= stb_nx;
         err_length <= len_nx;
      end
endmodule

// File: tb/tb_vegeta_output_streamer.sv
// tb_vegeta_output_streamer: directed jobs against a DEPTH=16 and a DEPTH=8 instance, scoreboarded streams.
module tb_vegeta_output_streamer;
   import vegeta_output_pkg::*;
   logic clk = 0, rst_n = 0, start = 0, start8 = 0, compute_done = 0, output_enable = 0;
   logic [31:0] output_address = 0, output_data = 0;
   logic [3:0] output_write = 0;
   logic job_done, busy, err_overflow, err_strobe, err_length;
   logic job_done8, busy8, ovf8, stb8, len8;
   int checks = 0, failures = 0, cyc = 0, last_pop = 0;
   logic [48:0] q[$], q8[$];
   int jd_q[$];
   logic [48:0] held;
   logic hold = 0;

   vegeta_output_streamer_if #(.ADDR_W(16)) s ();
   vegeta_output_streamer_if #(.ADDR_W(16)) s8 ();

   vegeta_output_streamer #(.M(4), .N(4), .DEPTH(16), .ADDR_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_multiplication(start), .compute_done(compute_done),
      .output_address(output_address), .output_data(output_data), .output_enable(output_enable),
      .output_write(output_write), .m(s), .job_done(job_done), .busy(busy),
      .err_overflow(err_overflow), .err_strobe(err_strobe), .err_length(err_length)
   );
   vegeta_output_streamer #(.M(4), .N(4), .DEPTH(8), .ADDR_W(16)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start_multiplication(start8), .compute_done(compute_done),
      .output_address(output_address), .output_data(output_data), .output_enable(output_enable),
      .output_write(output_write), .m(s8), .job_done(job_done8), .busy(busy8),
      .err_overflow(ovf8), .err_strobe(stb8), .err_length(len8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [48:0] ent(input bit l, input int a, input int d);
      return {l, a[15:0], d[31:0]};
   endfunction

   always @(negedge clk) begin
      logic [48:0] beat;
      cyc++;
      beat = {s.tlast, s.tuser, s.tdata};
      if (hold && rst_n) chk("hold_stable", {s.tvalid, beat}, {1'b1, held});
      hold = s.tvalid && !s.tready && rst_n;
      held = beat;
      if (s.tvalid && s.tready) begin
         last_pop = cyc;
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_beat got=%0h expected=none", beat);
         end else chk("beat", beat, q.pop_front());
      end
      if (job_done) begin
         if (jd_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_job_done got=1 expected=0");
         end else begin
            void'(jd_q.pop_front());
            chk("job_done_latency", cyc - last_pop, 1);
         end
      end
   end

   always @(negedge clk) begin
      logic [48:0] beat8;
      beat8 = {s8.tlast, s8.tuser, s8.tdata};
      if (s8.tvalid && s8.tready) begin
         if (q8.size() == 0) begin
            checks++; failures++;
            $display("FAIL extra_beat8 got=%0h expected=none", beat8);
         end else chk("beat8", beat8, q8.pop_front());
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input int a, input int d, input logic [3:0] w);
      output_enable = 1;
      output_address = a;
      output_data = d;
      output_write = w;
      step(1);
      output_enable = 0;
      output_write = 0;
   endtask

   task automatic go(input bit sel);
      if (sel) start8 = 1; else start = 1;
      step(1);
      start = 0;
      start8 = 0;
   endtask

   task automatic wait_jd(input bit sel);
      bit hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         hit = sel ? job_done8 : job_done;
      end
      chk(sel ? "job_done8_seen" : "job_done_seen", hit, 1);
      @(posedge clk);
      #1;
      compute_done = 0;
   endtask

   initial begin
      s.tready = 0;
      s8.tready = 0;
      step(2);
      chk("rst_tvalid", s.tvalid, 0);
      chk("rst_tdata", s.tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {err_overflow, err_strobe, err_length, job_done}, 0);
      rst_n = 1;
      step(1);

      s.tready = 1;
      go(0);
      chk("nom_busy", busy, 1);
      for (int i = 0; i < 16; i++) begin
         q.push_back(ent(i == 15, 32'h100 + i, i));
         wr(32'h100 + i, i, 4'hF);
      end
      compute_done = 1;
      jd_q.push_back(1);
      wait_jd(0);
      chk("nom_errs", {err_overflow, err_strobe, err_length}, 0);
      chk("nom_idle", busy, 0);

      s.tready = 0;
      go(0);
      for (int i = 0; i < 16; i++) begin
         q.push_back(ent(i == 15, 32'h500 + i, 32'hA000 + i));
         wr(32'h500 + i, 32'hA000 + i, 4'hF);
      end
      compute_done = 1;
      step(2);
      chk("bp_full", u_dut.u_fifo.full, 1);
      chk("bp_errs", {err_overflow, err_strobe, err_length}, 0);
      chk("bp_busy", busy, 1);
      jd_q.push_back(1);
      s.tready = 1;
      wait_jd(0);

      go(0);
      wr(32'h600, 32'hDEAD, 4'h3);
      chk("stb_flag", err_strobe, 1);
      for (int i = 0; i < 12; i++) begin
         q.push_back(ent(0, 32'h610 + i, 32'hB000 + i));
         wr(32'h610 + i, 32'hB000 + i, 4'hF);
      end
      compute_done = 1;
      jd_q.push_back(1);
      wait_jd(0);
      chk("len_flag", err_length, 1);
      chk("stb_sticky", err_strobe, 1);
      chk("len_no_ovf", err_overflow, 0);

      go(0);
      chk("start_clears", {err_strobe, err_length}, 0);
      for (int i = 0; i < 17; i++) begin
         if (i < 16) q.push_back(ent(i == 15, 32'h700 + i, 32'hC000 + i));
         wr(32'h700 + i, 32'hC000 + i, 4'hF);
      end
      chk("excess_len", err_length, 1);
      compute_done = 1;
      jd_q.push_back(1);
      wait_jd(0);
      go(0);
      chk("restart_clears", {err_overflow, err_strobe, err_length}, 0);

      s.tready = 0;
      for (int i = 0; i < 5; i++) wr(32'h800 + i, i, 4'hF);
      chk("pre_rst_valid", s.tvalid, 1);
      rst_n = 0;
      #1;
      chk("rst_valid_async", s.tvalid, 0);
      chk("rst_busy_async", busy, 0);
      step(1);
      rst_n = 1;
      step(1);
      chk("post_rst_idle", busy, 0);
      s.tready = 1;
      go(0);
      for (int i = 0; i < 16; i++) begin
         q.push_back(ent(i == 15, 32'h900 + i, 32'hE000 + i));
         wr(32'h900 + i, 32'hE000 + i, 4'hF);
      end
      compute_done = 1;
      jd_q.push_back(1);
      wait_jd(0);

      go(1);
      for (int i = 0; i < 10; i++) begin
         if (i < 8) q8.push_back(ent(0, 32'h300 + i, 32'h200 + i));
         wr(32'h300 + i, 32'h200 + i, 4'hF);
      end
      chk("ovf_flag", ovf8, 1);
      compute_done = 1;
      step(1);
      chk("ovf_len", len8, 1);
      s8.tready = 1;
      wait_jd(1);

      s8.tready = 0;
      go(1);
      chk("start8_clears", {ovf8, stb8, len8}, 0);
      for (int i = 0; i < 16; i++) begin
         q8.push_back(ent(i == 15, 32'h340 + i, 32'h400 + i));
         if (i == 8) s8.tready = 1;
         wr(32'h340 + i, 32'h400 + i, 4'hF);
         if (i == 8) begin
            chk("fullpop_count", u_dut8.u_fifo.count, 8);
            chk("fullpop_no_ovf", ovf8, 0);
         end
      end
      compute_done = 1;
      wait_jd(1);
      chk("fullpop_errs", {ovf8, stb8, len8}, 0);

      step(5);
      chk("q_drained", q.size(), 0);
      chk("q8_drained", q8.size(), 0);
      chk("job_done_all_seen", jd_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1);
   end
endmodule
